// File: rtl/rst_seq_ctrl.sv
// Reset sequencing controller: releases NUM_OUT active-low block resets one at a
// time after a programmable hold, and re-runs the sequence on a soft-reset edge.
module rst_seq_ctrl #(
  parameter int NUM_OUT   = 3,
  parameter int INIT_HOLD = 8,
  parameter int GAP       = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SOFT_RST_REQ,
  output logic [NUM_OUT-1:0] RST_OUT,
  output logic               SEQ_DONE,
  output logic               SOFT_RST_ACK
);

  localparam int MAX_HG = (INIT_HOLD > GAP) ? INIT_HOLD : GAP;
  localparam int CNT_W  = $clog2(MAX_HG) + 1;
  localparam int IDX_W  = $clog2(NUM_OUT) + 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ONE_HOT0  = NUM_OUT'(1);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             req_d;
  logic             pending;
  logic             rise;

  assign rise = SOFT_RST_REQ & ~req_d;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= HOLD;
      cnt          <= '0;
      idx          <= '0;
      RST_OUT      <= '0;
      SEQ_DONE     <= 1'b0;
      SOFT_RST_ACK <= 1'b0;
      pending      <= 1'b0;
      // A request already high when reset lifts must not look like a new edge.
      req_d        <= 1'b1;
    end else begin
      req_d        <= SOFT_RST_REQ;
      SOFT_RST_ACK <= 1'b0;

      case (state)
        HOLD: begin
          if (rise) pending <= 1'b1;
          if (cnt == HOLD_LAST) begin
            RST_OUT[0] <= 1'b1;
            cnt        <= '0;
            idx        <= IDX_W'(1);
            if (NUM_OUT == 1) begin
              state    <= RUN;
              SEQ_DONE <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RELEASE: begin
          if (rise) pending <= 1'b1;
          if (cnt == GAP_LAST) begin
            RST_OUT <= RST_OUT | (ONE_HOT0 << idx);
            cnt     <= '0;
            idx     <= idx + IDX_W'(1);
            if (idx == IDX_LAST) begin
              state    <= RUN;
              SEQ_DONE <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RUN: begin
          // Requests that arrived mid-sequence are serviced here, collapsed into one.
          if (rise || pending) begin
            RST_OUT      <= '0;
            SEQ_DONE     <= 1'b0;
            SOFT_RST_ACK <= 1'b1;
            pending      <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            state        <= HOLD;
          end
        end

        default: begin
          RST_OUT  <= '0;
          SEQ_DONE <= 1'b0;
          pending  <= 1'b0;
          cnt      <= '0;
          idx      <= '0;
          state    <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: table-driven edge checkpoints on the default
// configuration plus hand sequences for async reset and parameter corners.
module tb_rst_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       SOFT_RST_REQ = 1'b0;
  logic       req_c = 1'b0;
  logic [2:0] rst_out;
  logic       seq_done, soft_rst_ack;
  logic [0:0] rst_out1;
  logic       seq_done1, soft_rst_ack1;
  logic [3:0] rst_out4;
  logic       seq_done4, soft_rst_ack4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rst_seq_ctrl #(.NUM_OUT(3), .INIT_HOLD(8), .GAP(4)) dut (
    .CLK(CLK), .RST(RST), .SOFT_RST_REQ(SOFT_RST_REQ),
    .RST_OUT(rst_out), .SEQ_DONE(seq_done), .SOFT_RST_ACK(soft_rst_ack));

  rst_seq_ctrl #(.NUM_OUT(1), .INIT_HOLD(1), .GAP(1)) dut1 (
    .CLK(CLK), .RST(RST), .SOFT_RST_REQ(req_c),
    .RST_OUT(rst_out1), .SEQ_DONE(seq_done1), .SOFT_RST_ACK(soft_rst_ack1));

  rst_seq_ctrl #(.NUM_OUT(4), .INIT_HOLD(8), .GAP(1)) dut4 (
    .CLK(CLK), .RST(RST), .SOFT_RST_REQ(req_c),
    .RST_OUT(rst_out4), .SEQ_DONE(seq_done4), .SOFT_RST_ACK(soft_rst_ack4));

  typedef struct {
    int         scen;
    int         edge_no;
    logic [2:0] out;
    logic       done;
    logic       ack;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int s, input int e, input logic [2:0] o, input logic d, input logic a);
    vec_t v;
    v.scen = s; v.edge_no = e; v.out = o; v.done = d; v.ack = a;
    vecs.push_back(v);
  endtask

  task automatic check_main(input string tag, input logic [2:0] o, input logic d, input logic a);
    check({tag, " rst_out"}, 32'(rst_out), 32'(o));
    check({tag, " seq_done"}, 32'(seq_done), 32'(d));
    check({tag, " ack"}, 32'(soft_rst_ack), 32'(a));
  endtask

  // Reset all instances, then lift RST away from the clock edge; edge 1 follows.
  task automatic do_reset(input logic req_level);
    @(negedge CLK);
    RST = 1'b0;
    SOFT_RST_REQ = req_level;
    #1;
    check_main("reset", 3'b000, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic run_scen(input int s, input int n_edges, input logic [63:0] mask);
    do_reset(mask[1]);
    for (int e = 1; e <= n_edges; e++) begin
      SOFT_RST_REQ = mask[e];
      @(posedge CLK);
      #1;
      foreach (vecs[k]) begin
        if (vecs[k].scen == s && vecs[k].edge_no == e)
          check_main($sformatf("s%0d e%0d", s, e), vecs[k].out, vecs[k].done, vecs[k].ack);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] m;

    // Scenario 0: power-up then soft reset pulsed at edge 20.
    add(0, 1, 3'b000, 0, 0);  add(0, 7, 3'b000, 0, 0);
    add(0, 8, 3'b001, 0, 0);  add(0, 11, 3'b001, 0, 0);
    add(0, 12, 3'b011, 0, 0); add(0, 15, 3'b011, 0, 0);
    add(0, 16, 3'b111, 1, 0); add(0, 19, 3'b111, 1, 0);
    add(0, 20, 3'b000, 0, 1); add(0, 21, 3'b000, 0, 0);
    add(0, 27, 3'b000, 0, 0); add(0, 28, 3'b001, 0, 0);
    add(0, 32, 3'b011, 0, 0); add(0, 35, 3'b011, 0, 0);
    add(0, 36, 3'b111, 1, 0); add(0, 38, 3'b111, 1, 0);
    // Scenario 1: rises at edges 10 and 13 collapse into one pending request.
    add(1, 8, 3'b001, 0, 0);  add(1, 10, 3'b001, 0, 0);
    add(1, 12, 3'b011, 0, 0); add(1, 16, 3'b111, 1, 0);
    add(1, 17, 3'b000, 0, 1); add(1, 18, 3'b000, 0, 0);
    add(1, 24, 3'b000, 0, 0); add(1, 25, 3'b001, 0, 0);
    add(1, 29, 3'b011, 0, 0); add(1, 33, 3'b111, 1, 0);
    add(1, 35, 3'b111, 1, 0);
    // Scenario 2: request held high through reset; re-armed edge at 30.
    add(2, 1, 3'b000, 0, 0);  add(2, 8, 3'b001, 0, 0);
    add(2, 12, 3'b011, 0, 0); add(2, 16, 3'b111, 1, 0);
    add(2, 29, 3'b111, 1, 0); add(2, 30, 3'b000, 0, 1);
    add(2, 31, 3'b000, 0, 0); add(2, 38, 3'b001, 0, 0);
    add(2, 39, 3'b001, 0, 0);
    // Scenario 3/4: reset mid-sequence, then timing restarts from edge 1.
    add(3, 12, 3'b011, 0, 0);
    add(4, 7, 3'b000, 0, 0);  add(4, 8, 3'b001, 0, 0);
    add(4, 16, 3'b111, 1, 0);

    repeat (2) @(negedge CLK);

    m = '0; m[20] = 1'b1;
    run_scen(0, 38, m);

    m = '0; m[10] = 1'b1; m[13] = 1'b1;
    run_scen(1, 35, m);

    m = '1; m[29:25] = '0;
    run_scen(2, 39, m);

    m = '0;
    run_scen(3, 12, m);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_main("async mid-seq", 3'b000, 1'b0, 1'b0);
    run_scen(4, 16, m);

    // Parameter corners: both small instances restart together from edge 1.
    do_reset(1'b0);
    req_c = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      req_c = (e == 3);
      @(posedge CLK);
      #1;
      if (e == 1) begin
        check("n1 e1 out", 32'(rst_out1), 32'd1);
        check("n1 e1 done", 32'(seq_done1), 32'd1);
      end
      if (e == 3) begin
        check("n1 e3 out", 32'(rst_out1), 32'd0);
        check("n1 e3 ack", 32'(soft_rst_ack1), 32'd1);
      end
      if (e == 4) begin
        check("n1 e4 out", 32'(rst_out1), 32'd1);
        check("n1 e4 done", 32'(seq_done1), 32'd1);
        check("n1 e4 ack", 32'(soft_rst_ack1), 32'd0);
      end
      if (e == 7)  check("n4 e7 out", 32'(rst_out4), 32'h0);
      if (e == 8)  check("n4 e8 out", 32'(rst_out4), 32'h1);
      if (e == 9)  check("n4 e9 out", 32'(rst_out4), 32'h3);
      if (e == 10) begin
        check("n4 e10 out", 32'(rst_out4), 32'h7);
        check("n4 e10 done", 32'(seq_done4), 32'd0);
      end
      if (e == 11) begin
        check("n4 e11 out", 32'(rst_out4), 32'hf);
        check("n4 e11 done", 32'(seq_done4), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
